shift_arb_ctrl: RTL

Two-requester arbiter and sequencer for the shared 8-bit serial-in shift register. Each requester presents a parallel byte; the block grants one requester at a time in round-robin order, captures its byte, and streams it bit-serially with a qualifying shift enable into the shift register's serial input. A done pulse marks frame end.

---
 rtl/shift_arb_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: two-requester round-robin arbiter that captures the winner's
// parallel word and streams it bit-serially (o_sen qualifies o_sdata) into a
// shared serial-in shift register, closing each frame with an o_done pulse.
// Optional build macro SHIFT_ARB_CTRL_PARITY_EN appends one even-parity bit
// as an extra o_sen cycle after the last data bit.
module shift_arb_ctrl #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  output logic [1:0]        o_ack,
  output logic              o_gnt_id,
  output logic              o_busy,
  output logic              o_sen,
  output logic              o_sdata,
  output logic              o_done
);

  localparam int CW = $clog2(DATA_W + 1);
`ifdef SHIFT_ARB_CTRL_PARITY_EN
  // Counter runs one past the data bits; the extra count is the parity slot.
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
`else
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic              win;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
  logic              par_q, par_d;
`endif

  // On a tie the requester not granted last wins; a lone request always wins.
  assign win = (i_req == 2'b11) ? ~ptr_q : i_req[1];

  // Next-state and capture logic; requests are only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = 2'b00;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|i_req) begin
          ptr_d   = win;
          gnt_d   = win;
          ack_d   = win ? 2'b10 : 2'b01;
          frame_d = win ? i_data1 : i_data0;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
          par_d   = win ? ^i_data1 : ^i_data0;
`endif
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        // The frame register shifts so the outgoing bit is always at one end.
        if (MSB_FIRST) frame_d = frame_q << 1;
        else           frame_d = frame_q >> 1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      gnt_q   <= 1'b0;
      ack_q   <= 2'b00;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
`ifdef SHIFT_ARB_CTRL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Serial bit: head of the frame register, parity in the extra slot, 0 when idle.
  always_comb begin
    o_sdata = 1'b0;
    if (state_q == SHIFT) begin
`ifdef SHIFT_ARB_CTRL_PARITY_EN
      if (cnt_q == LAST) o_sdata = par_q;
      else
`endif
      o_sdata = MSB_FIRST ? frame_q[DATA_W-1] : frame_q[0];
    end
  end

  assign o_ack    = ack_q;
  assign o_gnt_id = gnt_q;
  assign o_busy   = (state_q != IDLE);
  assign o_sen    = (state_q == SHIFT);
  assign o_done   = (state_q == DONE);

endmodule
